// File: rtl/axi_ctrl_trans_sched.sv
// Single-outstanding scheduler: pops LS (AXI-Lite request) or SS (AXI-Stream beat)
// entries round-robin, drives the LM/SM start/done handshake and guards it with a watchdog.
module axi_ctrl_trans_sched #(
  parameter logic [31:0] LM_BASE = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        ls_vld,
  output logic        ls_rdy,
  input  logic [51:0] ls_data,
  input  logic        ss_vld,
  output logic        ss_rdy,
  input  logic [44:0] ss_data,
  output logic        lm_wstart,
  output logic [31:0] lm_waddr,
  output logic [31:0] lm_wdata,
  output logic [3:0]  lm_wstrb,
  input  logic        lm_wdone,
  output logic        lm_rstart,
  output logic [31:0] lm_raddr,
  input  logic [31:0] lm_rdata,
  input  logic        lm_rdone,
  output logic [31:0] ls_rdata,
  output logic        ls_rdone,
  output logic        sm_start,
  output logic [31:0] sm_data,
  output logic [3:0]  sm_tstrb,
  output logic [3:0]  sm_tkeep,
  output logic [1:0]  sm_user,
  output logic        sm_tlast,
  input  logic        sm_nordy,
  input  logic        sm_done,
  input  logic        err_clr,
  output logic        busy,
  output logic        err,
  output logic        axi_interrupt
);

  typedef enum logic [2:0] {IDLE, LS_WR, LS_RD, SS_WAIT, SS_TX} state_t;

  state_t      state_q, state_d;
  logic        armed_q;
  logic        first_q;
  logic        last_ls_q;
  logic        ss_lock_q;
  logic        err_q;
  logic        ls_rdone_q;
  logic [15:0] timer_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] sm_data_q;
  logic [3:0]  sm_tstrb_q, sm_tkeep_q;
  logic [1:0]  sm_user_q;
  logic        sm_tlast_q;

  logic elig_ls, elig_ss, grant_ls, grant_ss;
  logic eng_busy, eng_done, timer_last, timeout_hit;
  logic unused_rsvd;

  assign unused_rsvd = ^ss_data[1:0];

  // armed_q keeps the FIFOs from being popped while reset is still asserted.
  assign elig_ls  = armed_q && ls_vld && !ss_lock_q;
  assign elig_ss  = armed_q && ss_vld;
  assign grant_ls = elig_ls && (!elig_ss || !last_ls_q);
  assign grant_ss = elig_ss && !grant_ls;

  assign eng_busy    = (state_q == LS_WR) || (state_q == LS_RD) || (state_q == SS_TX);
  assign eng_done    = ((state_q == LS_WR) && lm_wdone) ||
                       ((state_q == LS_RD) && lm_rdone) ||
                       ((state_q == SS_TX) && sm_done);
  assign timer_last  = (timer_q == TIMEOUT - 16'd1);
  assign timeout_hit = eng_busy && !eng_done && timer_last;

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ls_rdy    = 1'b0;
    ss_rdy    = 1'b0;
    lm_wstart = 1'b0;
    lm_rstart = 1'b0;
    sm_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ls_rdy = grant_ls;
        ss_rdy = grant_ss;
        if (grant_ls)      state_d = ls_data[51] ? LS_WR : LS_RD;
        else if (grant_ss) state_d = SS_WAIT;
      end
      LS_WR:   lm_wstart = first_q;
      LS_RD:   lm_rstart = first_q;
      SS_WAIT: begin
        if (!sm_nordy) begin
          sm_start = 1'b1;
          state_d  = SS_TX;
        end
      end
      SS_TX:   ;
      default: state_d = IDLE;
    endcase
    if (eng_done || timeout_hit) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      first_q    <= 1'b0;
      last_ls_q  <= 1'b0;
      ss_lock_q  <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= 16'd0;
      ls_rdone_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      armed_q    <= 1'b1;
      first_q    <= ls_rdy;
      ls_rdone_q <= (state_q == LS_RD) && lm_rdone;
      if ((state_q == LS_RD) && lm_rdone) rdata_q <= lm_rdata;

      if (ls_rdy)      last_ls_q <= 1'b1;
      else if (ss_rdy) last_ls_q <= 1'b0;

      // Timer counts from the start pulse; SS_WAIT back-pressure is not timed.
      if (ls_rdy || sm_start)                       timer_q <= 16'd0;
      else if (eng_busy && !eng_done && !timer_last) timer_q <= timer_q + 16'd1;

      if ((state_q == SS_TX) && sm_done) ss_lock_q <= !sm_tlast_q;
      else if (timeout_hit)              ss_lock_q <= 1'b0;

      if (timeout_hit)  err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  // NOTE: the holding registers are reset even though they only carry data, because
  // they drive module outputs directly and those must read zero out of reset.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      sm_data_q  <= 32'd0;
      sm_tstrb_q <= 4'd0;
      sm_tkeep_q <= 4'd0;
      sm_user_q  <= 2'd0;
      sm_tlast_q <= 1'b0;
    end else begin
      if (ls_rdy) begin
        addr_q  <= LM_BASE + {17'd0, ls_data[50:36]};
        wdata_q <= ls_data[35:4];
        wstrb_q <= ls_data[3:0];
      end
      if (ss_rdy) begin
        sm_data_q  <= ss_data[44:13];
        sm_tstrb_q <= ss_data[12:9];
        sm_tkeep_q <= ss_data[8:5];
        sm_user_q  <= ss_data[4:3];
        sm_tlast_q <= ss_data[2];
      end
    end
  end

  assign lm_waddr      = addr_q;
  assign lm_raddr      = addr_q;
  assign lm_wdata      = wdata_q;
  assign lm_wstrb      = wstrb_q;
  assign ls_rdata      = rdata_q;
  assign ls_rdone      = ls_rdone_q;
  assign sm_data       = sm_data_q;
  assign sm_tstrb      = sm_tstrb_q;
  assign sm_tkeep      = sm_tkeep_q;
  assign sm_user       = sm_user_q;
  assign sm_tlast      = sm_tlast_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;
  assign axi_interrupt = err_q;

endmodule

// File: tb/tb_axi_ctrl_trans_sched.sv
// Self-checking bench: FIFO heads come from bench queues, engines are modelled here,
// and the grant order is predicted at transaction level from the arbitration rules.
module tb_axi_ctrl_trans_sched;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [15:0] TMO  = 16'd8;
  localparam byte G_LS = "L";
  localparam byte G_SS = "S";

  logic        axi_aclk, axi_aresetn;
  logic        ls_vld, ls_rdy, ss_vld, ss_rdy;
  logic [51:0] ls_data;
  logic [44:0] ss_data;
  logic        lm_wstart, lm_wdone, lm_rstart, lm_rdone;
  logic [31:0] lm_waddr, lm_wdata, lm_raddr, lm_rdata, ls_rdata;
  logic [3:0]  lm_wstrb, sm_tstrb, sm_tkeep;
  logic        ls_rdone, sm_start, sm_tlast, sm_nordy, sm_done;
  logic [31:0] sm_data;
  logic [1:0]  sm_user;
  logic        err_clr, busy, err, axi_interrupt;

  axi_ctrl_trans_sched #(.LM_BASE(BASE), .TIMEOUT(TMO)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .ls_vld(ls_vld), .ls_rdy(ls_rdy), .ls_data(ls_data),
    .ss_vld(ss_vld), .ss_rdy(ss_rdy), .ss_data(ss_data),
    .lm_wstart(lm_wstart), .lm_waddr(lm_waddr), .lm_wdata(lm_wdata), .lm_wstrb(lm_wstrb),
    .lm_wdone(lm_wdone),
    .lm_rstart(lm_rstart), .lm_raddr(lm_raddr), .lm_rdata(lm_rdata), .lm_rdone(lm_rdone),
    .ls_rdata(ls_rdata), .ls_rdone(ls_rdone),
    .sm_start(sm_start), .sm_data(sm_data), .sm_tstrb(sm_tstrb), .sm_tkeep(sm_tkeep),
    .sm_user(sm_user), .sm_tlast(sm_tlast), .sm_nordy(sm_nordy), .sm_done(sm_done),
    .err_clr(err_clr), .busy(busy), .err(err), .axi_interrupt(axi_interrupt)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  int          total = 0;
  int          bad   = 0;
  logic [51:0] ls_q[$];
  logic [44:0] ss_q[$];
  byte         exp_grants[$];
  int          nordy_plan[$];
  bit          m_last_ls, m_lock;
  int          fixed_dly   = -1;
  bit          fixed_rd_en = 1'b0;
  logic [31:0] fixed_rd    = '0;
  logic [31:0] seen_addr   = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ctrl"}, {ls_rdy, ss_rdy, lm_wstart, lm_rstart, ls_rdone, sm_start,
                           sm_tlast, busy, err, axi_interrupt}, 0);
    check({pfx, "_addr"}, {lm_waddr, lm_raddr}, 0);
    check({pfx, "_data"}, {lm_wdata, ls_rdata}, 0);
    check({pfx, "_sm"},   {sm_data, sm_tstrb, sm_tkeep, sm_user, lm_wstrb}, 0);
  endtask

  task automatic apply_heads();
    ls_vld  = (ls_q.size() != 0);
    ls_data = ls_vld ? ls_q[0] : '0;
    ss_vld  = (ss_q.size() != 0);
    ss_data = ss_vld ? ss_q[0] : '0;
  endtask

  // Transaction-level arbitration: queued entries are all visible, so the order
  // depends only on round-robin history and the packet lock.
  function automatic void build_model();
    int nl;
    int si;
    bit el, es;
    nl = ls_q.size();
    si = 0;
    exp_grants.delete();
    while (nl > 0 || si < ss_q.size()) begin
      el = (nl > 0) && !m_lock;
      es = (si < ss_q.size());
      if (!el && !es) break;
      if (el && (!es || !m_last_ls)) begin
        exp_grants.push_back(G_LS);
        nl--;
        m_last_ls = 1'b1;
      end else begin
        exp_grants.push_back(G_SS);
        m_lock = !ss_q[si][2];
        si++;
        m_last_ls = 1'b0;
      end
    end
  endfunction

  task automatic do_reset();
    axi_aresetn = 1'b0;
    ls_vld  = 1'b1;
    ss_vld  = 1'b1;
    ls_data = {1'b1, 15'h1234, 32'hA5A5_5A5A, 4'hF};
    ss_data = {32'h0BAD_F00D, 4'hF, 4'hF, 2'h3, 1'b1, 2'b00};
    repeat (2) @(posedge axi_aclk);
    @(negedge axi_aclk);
    check_all_zero("rst");
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    ls_vld = 1'b0;
    ss_vld = 1'b0;
    m_last_ls = 1'b0;
    m_lock    = 1'b0;
  endtask

  // Plays FIFO heads and both engines until every queued entry has completed.
  task automatic run_traffic(input int budget);
    int cyc, dly, nordy_left, nordy_cur, gi, starts, grant_cyc;
    bit pending, done_now, rd_issued, exp_rdone, is_ls;
    logic [51:0] cur_ls;
    logic [44:0] cur_ss;
    logic [31:0] exp_rdata;
    cyc = 0; dly = -1; nordy_left = 0; nordy_cur = 0; gi = 0; starts = 0; grant_cyc = 0;
    pending = 0; done_now = 0; rd_issued = 0; exp_rdone = 0; is_ls = 0;
    cur_ls = '0; cur_ss = '0; exp_rdata = '0;
    build_model();
    apply_heads();
    while (cyc < budget && (ls_q.size() != 0 || ss_q.size() != 0 || pending ||
                            done_now || rd_issued || exp_rdone)) begin
      @(negedge axi_aclk);
      if (exp_rdone) begin
        check("ls_rdone", ls_rdone, 1);
        check("ls_rdata", ls_rdata, exp_rdata);
        exp_rdone = 0;
      end else if (ls_rdone) begin
        check("ls_rdone_spurious", ls_rdone, 0);
      end
      if (ls_rdy || ss_rdy) begin
        check("grant_when_idle", busy, 0);
        check("single_pop", ls_rdy && ss_rdy, 0);
        check("grant_order", ls_rdy ? G_LS : G_SS,
              gi < exp_grants.size() ? exp_grants[gi] : 8'h3F);
        gi++;
        pending = 1; starts = 0; grant_cyc = cyc; is_ls = ls_rdy;
        if (ls_rdy) cur_ls = ls_q.pop_front();
        else begin
          cur_ss = ss_q.pop_front();
          nordy_left = (nordy_plan.size() != 0) ? nordy_plan.pop_front() : $urandom_range(0, 3);
          nordy_cur  = nordy_left;
        end
      end
      if (lm_wstart || lm_rstart || sm_start) begin
        starts++;
        check("start_once", starts, 1);
        if (is_ls) begin
          check("lm_start_kind", {lm_wstart, lm_rstart, sm_start}, cur_ls[51] ? 3'b100 : 3'b010);
          check("lm_start_lat", cyc - grant_cyc, 1);
          seen_addr = cur_ls[51] ? lm_waddr : lm_raddr;
          check("lm_addr", seen_addr, BASE + {17'd0, cur_ls[50:36]});
          if (cur_ls[51]) check("lm_wstrb", lm_wstrb, cur_ls[3:0]);
        end else begin
          check("sm_start_kind", {lm_wstart, lm_rstart, sm_start}, 3'b001);
          check("sm_start_lat", cyc - grant_cyc, nordy_cur + 1);
          check("sm_fields", {sm_data, sm_tstrb, sm_tkeep, sm_user, sm_tlast}, cur_ss[44:2]);
        end
        dly = (fixed_dly > 0) ? fixed_dly : $urandom_range(1, 5);
      end
      if (pending && is_ls && cur_ls[51] && starts > 0)
        check("lm_wdata_hold", lm_wdata, cur_ls[35:4]);
      @(posedge axi_aclk); #1;
      cyc++;
      lm_wdone = 1'b0; lm_rdone = 1'b0; sm_done = 1'b0;
      if (rd_issued) begin exp_rdone = 1; rd_issued = 0; end
      if (done_now) begin
        check("busy_drop", busy, 0);
        pending = 0; done_now = 0;
      end
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          dly = -1; done_now = 1;
          if (!is_ls) sm_done = 1'b1;
          else if (cur_ls[51]) lm_wdone = 1'b1;
          else begin
            exp_rdata = fixed_rd_en ? fixed_rd : $urandom();
            lm_rdata  = exp_rdata;
            lm_rdone  = 1'b1;
            rd_issued = 1;
          end
        end
      end
      if (nordy_left > 0) begin sm_nordy = 1'b1; nordy_left--; end
      else sm_nordy = 1'b0;
      apply_heads();
    end
    check("traffic_budget", cyc < budget, 1);
    check("grant_count", gi, exp_grants.size());
  endtask

  // Issues one LS write that the engine never answers; returns busy cycles until abort.
  task automatic hang_write(input bit clr_last, output int busy_cycles);
    bit got;
    got = 0;
    busy_cycles = 0;
    ls_data = {1'b1, 15'h0123, 32'hCAFE_F00D, 4'h3};
    ls_vld  = 1'b1;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge axi_aclk);
      got = ls_rdy;
      @(posedge axi_aclk); #1;
    end
    check("hang_grant", got, 1);
    ls_vld = 1'b0;
    m_last_ls = 1'b1;
    for (int w = 0; w < 40; w++) begin
      err_clr = clr_last && (busy_cycles == TMO - 1);
      @(negedge axi_aclk);
      if (!busy) break;
      busy_cycles++;
      @(posedge axi_aclk); #1;
    end
    err_clr = 1'b0;
    @(posedge axi_aclk); #1;
  endtask

  function automatic logic [51:0] rand_ls();
    return {1'($urandom_range(0, 1)), 15'($urandom), 32'($urandom), 4'($urandom)};
  endfunction

  function automatic logic [44:0] rand_ss(input bit last);
    return {32'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), last, 2'b00};
  endfunction

  initial begin
    int n;
    axi_aresetn = 1'b0;
    ls_vld = 1'b0; ls_data = '0; ss_vld = 1'b0; ss_data = '0;
    lm_wdone = 1'b0; lm_rdone = 1'b0; lm_rdata = '0;
    sm_nordy = 1'b0; sm_done = 1'b0; err_clr = 1'b0;

    do_reset();

    // Directed LS write, engine answers three cycles after the start pulse.
    ls_q.push_back({1'b1, 15'h0010, 32'hDEADBEEF, 4'hF});
    fixed_dly = 3;
    run_traffic(200);
    fixed_dly = -1;
    check("dir_waddr", seen_addr, 32'h3000_0010);

    // Directed LS read at the top of the 15-bit window.
    ls_q.push_back({1'b0, 15'h7FFF, 36'd0});
    fixed_rd_en = 1'b1;
    fixed_rd    = 32'h1234_5678;
    run_traffic(200);
    fixed_rd_en = 1'b0;
    check("dir_raddr", seen_addr, 32'h3000_7FFF);
    check("dir_rdata_hold", ls_rdata, 32'h1234_5678);

    // Both sources valid, single-beat packets: alternation starting with LS.
    do_reset();
    for (int i = 0; i < 4; i++) ls_q.push_back(rand_ls());
    for (int i = 0; i < 3; i++) ss_q.push_back(rand_ss(1'b1));
    run_traffic(500);

    // Three-beat packet with LS pending; long back-pressure must not trip the watchdog.
    for (int i = 0; i < 2; i++) ls_q.push_back(rand_ls());
    ss_q.push_back(rand_ss(1'b0));
    ss_q.push_back(rand_ss(1'b0));
    ss_q.push_back(rand_ss(1'b1));
    nordy_plan.push_back(5);
    nordy_plan.push_back(12);
    nordy_plan.push_back(0);
    run_traffic(500);
    check("no_timeout_in_wait", err, 0);

    // Random mix with random packet boundaries.
    for (int i = 0; i < 10; i++) ls_q.push_back(rand_ls());
    for (int i = 0; i < 9; i++) ss_q.push_back(rand_ss(1'($urandom_range(0, 1))));
    ss_q.push_back(rand_ss(1'b1));
    run_traffic(3000);
    check("no_err_random", {err, axi_interrupt}, 2'b00);

    // Watchdog abort, late done, recovery, clear and set-over-clear priority.
    hang_write(1'b0, n);
    check("timeout_cycles", n, TMO);
    check("timeout_err", {err, axi_interrupt}, 2'b11);
    lm_wdone = 1'b1;
    @(posedge axi_aclk); #1;
    lm_wdone = 1'b0;
    @(negedge axi_aclk);
    check("late_done_ignored", {busy, err}, 2'b01);
    @(posedge axi_aclk); #1;
    ls_q.push_back({1'b0, 15'h0055, 36'd0});
    run_traffic(200);
    check("err_sticky", err, 1);
    err_clr = 1'b1;
    @(posedge axi_aclk); #1;
    err_clr = 1'b0;
    @(negedge axi_aclk);
    check("err_cleared", {err, axi_interrupt}, 2'b00);
    @(posedge axi_aclk); #1;
    hang_write(1'b1, n);
    check("timeout_cycles2", n, TMO);
    check("set_beats_clr", {err, axi_interrupt}, 2'b11);

    // Asynchronous reset in the middle of an LS read.
    ls_data = {1'b0, 15'h0042, 36'd0};
    ls_vld  = 1'b1;
    n = 0;
    for (int w = 0; w < 20 && n == 0; w++) begin
      @(negedge axi_aclk);
      n = ls_rdy ? 1 : 0;
      @(posedge axi_aclk); #1;
    end
    ls_vld = 1'b0;
    @(posedge axi_aclk); #1;
    check("rd_inflight", {n[0], busy}, 2'b11);
    #2;
    axi_aresetn = 1'b0;
    #1;
    check_all_zero("arst");
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    m_last_ls = 1'b0;
    m_lock    = 1'b0;
    ls_q.push_back({1'b0, 15'h0007, 36'd0});
    ss_q.push_back(rand_ss(1'b1));
    run_traffic(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
